key_event_scheduler: RTL and testbench
======================================

Name: key_event_scheduler

Overview:
- Front end between the board push-buttons (KEY) and any key-driven FSM in the design.
- Per key: synchronise, debounce, detect a release (rising edge of the active-low KEY level).
- Arbitrates release events from all keys round-robin into a small FIFO and delivers exactly one event ID at a time to the consumer FSM over a valid/ready handshake.
- Replaces the raw per-key edge strobes, which lose simultaneous presses and bounce.

Parameters:
- NUM_KEYS, 3: number of KEY inputs scheduled (2..8).
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles needed to accept a level change (10 ms at 50 MHz); must be >= 2.
- FIFO_DEPTH, 4: event queue entries; power of two, >= 2.
- ID_W, $clog2(NUM_KEYS): width of event_id.

Ports:
- CLOCK_50  in  1  single system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- KEY  in  NUM_KEYS  raw asynchronous buttons, active-low (pressed = 0).
- event_valid  out  1  FIFO head holds an event.
- event_id  out  ID_W  index of the key released; meaningful only while event_valid=1.
- event_ready  in  1  consumer accepts head this cycle.
- overflow  out  1  sticky; an event was dropped.

Behaviour:
- Clock and reset: one clock (CLOCK_50); reset is synchronous and active-high. No asynchronous set/reset anywhere in the block.
- Reset values: event_valid=0, event_id=0, overflow=0. FIFO empty, all pending bits 0, round-robin pointer = NUM_KEYS-1 (key 0 has highest priority first). Sync flops and debounced levels reset to 1 (released), so a held key at reset-release produces no event until it is released.
- Synchroniser: 2 flops per key.
- Debounce, per key:
  - A counter runs while the synchronised level differs from the debounced level, and clears whenever they match.
  - The debounced level flips on the edge where the difference has held for DEBOUNCE_CYCLES consecutive edges.
  - Any glitch shorter than that produces no change.
- Edge detect: a debounced 0->1 transition sets pending[k] on the next edge. A press (1->0) generates nothing.
- Arbiter:
  - Each cycle the FIFO is not full and any pending bit is set, grant the first set bit searching from pointer+1 upward with wrap.
  - On grant: push k, clear pending[k], set pointer to k.
  - At most one grant per cycle.
- Dropped events: a new edge on key k while pending[k] is already 1 is dropped and sets overflow. Overflow clears only on reset.
- Pending edge in the same cycle as its grant: the grant clears the old event and the new edge re-sets pending[k]; not a drop.
- FIFO:
  - Push allowed only when occupancy < FIFO_DEPTH, using registered occupancy. When full, pending bits wait; they are not dropped.
  - Pop when event_valid & event_ready.
  - Simultaneous push and pop on a non-full, non-empty FIFO keeps occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Output registering: event_valid and event_id are registered FIFO head/empty state. event_id must stay stable while event_valid=1 and event_ready=0.
- Latency: KEY rises, stays stable, FIFO empty, no competitors -> event_valid=1 exactly DEBOUNCE_CYCLES+4 edges after the first edge sampling KEY high.
- Reset mid-operation: a reset asserted on any edge discards FIFO contents, pending bits and partial debounce counts. Outputs are at reset values on the following cycle.

Decomposition:
- Package key_event_pkg: DEBOUNCE_CYCLES default, FIFO_DEPTH default, ID_W derivation function.
- Sub-module key_debouncer: 2-flop sync, counter, debounced level and release strobe for one key; instantiated NUM_KEYS times.
- Arbiter and FIFO stay in the top level.

Test Plan (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4, NUM_KEYS=3):
- Single release: KEY[1] 0->1 held, ready=1 -> event_valid pulses 1 cycle at edge 8 with event_id=1; overflow=0.
- Bounce: KEY[0] toggles every 2 cycles for 20 cycles, then stays 0 -> no event; then stays 1 -> exactly one event with id=0.
- Simultaneous: KEY[0], KEY[1], KEY[2] released on the same edge, ready=1 -> ids 0,1,2 on consecutive cycles. Repeat -> still 0,1,2, since the pointer is at 2.
- Backpressure: ready=0, six staggered releases of keys 0,1,2,0,1,2 -> FIFO fills with 0,1,2,0, and pending holds 1,2. Then ready=1 -> sequence 0,1,2,0,1,2; event_id stable while stalled; overflow=0.
- Overflow: ready=0, FIFO full, key 2 pending, key 2 released again -> overflow=1 and remains 1 after draining. Only one id=2 is delivered from the pending bit.
- Reset mid-operation: FIFO holds 3 events and a debounce is half-counted, reset for 1 cycle -> event_valid=0, overflow=0. No event from the half-counted key unless it completes a fresh DEBOUNCE_CYCLES window.

Source files
------------

// File: rtl/key_event_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_event_pkg
// Description : Shared defaults and width helper for the key event scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package key_event_pkg;

    localparam int NUM_KEYS_DEF        = 3;
    localparam int DEBOUNCE_CYCLES_DEF = 500000;
    localparam int FIFO_DEPTH_DEF      = 4;

    // Event ID width; never narrower than one bit.
    function automatic int id_width(input int num_keys);
        return (num_keys > 1) ? $clog2(num_keys) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_event_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : key_event_scheduler_if
// Description : Event delivery handshake between scheduler and consumer FSM.
// Revision    : 1.0 - initial release
// ============================================================================
interface key_event_scheduler_if #(
    parameter int ID_W = key_event_pkg::id_width(key_event_pkg::NUM_KEYS_DEF)
);
    logic            event_valid;
    logic [ID_W-1:0] event_id;
    logic            event_ready;
    logic            overflow;

    modport master (
        output event_valid,
        output event_id,
        output overflow,
        input  event_ready
    );

    modport slave (
        input  event_valid,
        input  event_id,
        input  overflow,
        output event_ready
    );
endinterface
`default_nettype wire

// File: rtl/key_event_scheduler_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : key_debouncer
// Description : Two-flop synchroniser, debounce counter and release strobe
//               for one active-low push-button.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = key_event_pkg::DEBOUNCE_CYCLES_DEF
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_key,
    output logic      o_release
);

    localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_release;
    logic [c_CNT_W-1:0] r_cnt;

    // Released (1) is the idle level, so a key held through reset stays quiet.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_level   <= 1'b1;
            r_cnt     <= '0;
            r_release <= 1'b0;
        end else begin
            r_sync1   <= i_key;
            r_sync2   <= r_sync1;
            r_release <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_level   <= r_sync2;
                r_cnt     <= '0;
                r_release <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_release = r_release;

endmodule
`default_nettype wire

// File: rtl/key_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : key_event_scheduler
// Description : Debounces KEY inputs and delivers release events one at a time
//               through a round-robin arbiter and small FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module key_event_scheduler
    import key_event_pkg::*;
#(
    parameter int NUM_KEYS        = NUM_KEYS_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int FIFO_DEPTH      = FIFO_DEPTH_DEF,
    parameter int ID_W            = id_width(NUM_KEYS)
) (
    input  wire logic                CLOCK_50,
    input  wire logic                reset,
    input  wire logic [NUM_KEYS-1:0] KEY,
    key_event_scheduler_if.master    evt
);

    localparam int                 c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int                 c_CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(FIFO_DEPTH);
    localparam logic [ID_W-1:0]    c_RR_INIT = ID_W'(NUM_KEYS - 1);

    logic [NUM_KEYS-1:0] w_release;
    logic [NUM_KEYS-1:0] r_pending;
    logic [NUM_KEYS-1:0] w_pending_next;
    logic [NUM_KEYS-1:0] w_grant_vec;
    logic                w_grant_any;
    logic [ID_W-1:0]     w_grant_id;
    logic [ID_W-1:0]     r_rr_ptr;
    logic                w_can_push;
    logic                w_drop;
    logic                r_overflow;

    logic [ID_W-1:0]     r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_PTR_W-1:0]  w_rd_next;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_CNT_W-1:0]  w_count_next;
    logic                w_pop;
    logic                r_valid;
    logic [ID_W-1:0]     r_head;
    logic [ID_W-1:0]     w_head_next;

    generate
        for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
            key_debouncer #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debouncer (
                .clk      (CLOCK_50),
                .rst      (reset),
                .i_key    (KEY[k]),
                .o_release(w_release[k])
            );
        end
    endgenerate

    assign w_can_push = (r_count < c_DEPTH);

    // Search starts one past the last grant and wraps; first hit wins.
    always_comb begin
        w_grant_vec = '0;
        w_grant_any = 1'b0;
        w_grant_id  = '0;
        for (int i = 1; i <= NUM_KEYS; i++) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (((int'(r_rr_ptr) + i) % NUM_KEYS) == k && r_pending[k] &&
                    w_can_push && !w_grant_any) begin
                    w_grant_vec[k] = 1'b1;
                    w_grant_any    = 1'b1;
                    w_grant_id     = ID_W'(k);
                end
            end
        end
    end

    // A release landing on its own grant cycle re-arms the bit instead of dropping.
    assign w_pending_next = (r_pending & ~w_grant_vec) | w_release;
    assign w_drop         = |(w_release & r_pending & ~w_grant_vec);

    assign w_pop        = r_valid & evt.event_ready;
    assign w_rd_next    = r_rd_ptr + {{(c_PTR_W-1){1'b0}}, w_pop};
    assign w_count_next = r_count + {{(c_CNT_W-1){1'b0}}, w_grant_any}
                                  - {{(c_CNT_W-1){1'b0}}, w_pop};

    always_comb begin
        w_head_next = '0;
        if (w_count_next != '0) begin
            if (w_grant_any && (w_rd_next == r_wr_ptr)) begin
                w_head_next = w_grant_id;
            end else begin
                w_head_next = r_mem[w_rd_next];
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (w_grant_any) begin
            r_mem[r_wr_ptr] <= w_grant_id;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_pending  <= '0;
            r_rr_ptr   <= c_RR_INIT;
            r_overflow <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_head     <= '0;
        end else begin
            r_pending  <= w_pending_next;
            r_overflow <= r_overflow | w_drop;
            if (w_grant_any) begin
                r_rr_ptr <= w_grant_id;
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr <= w_rd_next;
            r_count  <= w_count_next;
            r_valid  <= (w_count_next != '0);
            r_head   <= w_head_next;
        end
    end

    assign evt.event_valid = r_valid;
    assign evt.event_id    = r_head;
    assign evt.overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_key_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_event_scheduler
// Description : Directed self-checking bench for key_event_scheduler
//               (3 keys, 4-cycle debounce, 4-entry FIFO).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_event_scheduler;

    logic       CLOCK_50;
    logic       reset;
    logic [2:0] KEY;
    int         n_cmp;
    int         n_err;

    key_event_scheduler_if #(.ID_W(2)) evt_bus ();

    key_event_scheduler #(
        .NUM_KEYS       (3),
        .DEBOUNCE_CYCLES(4),
        .FIFO_DEPTH     (4)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .KEY     (KEY),
        .evt     (evt_bus)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input int k);
        KEY[k] = 1'b0;
        step(6);
    endtask

    // Release with an idle FIFO and ready=1: one-cycle event at edge 8.
    task automatic single_release(input string tag, input int k);
        KEY[k] = 1'b1;
        step(7);
        chk({tag, "_pre_valid"}, 32'(evt_bus.event_valid), 32'd0);
        step(1);
        chk({tag, "_valid"}, 32'(evt_bus.event_valid), 32'd1);
        chk({tag, "_id"}, 32'(evt_bus.event_id), 32'(k));
        step(1);
        chk({tag, "_post_valid"}, 32'(evt_bus.event_valid), 32'd0);
    endtask

    // Release while stalled; the event has been arbitrated by the end.
    task automatic queued_release(input int k);
        KEY[k] = 1'b1;
        step(8);
    endtask

    initial begin
        int exp4 [5];
        int exp5 [4];
        exp4 = '{1, 2, 0, 1, 2};
        exp5 = '{1, 2, 0, 2};
        n_cmp = 0;
        n_err = 0;
        KEY   = 3'b111;
        reset = 1'b1;
        evt_bus.event_ready = 1'b1;
        step(3);
        chk("rst_valid", 32'(evt_bus.event_valid), 32'd0);
        chk("rst_id", 32'(evt_bus.event_id), 32'd0);
        chk("rst_ovf", 32'(evt_bus.overflow), 32'd0);
        reset = 1'b0;
        step(2);

        // Single release of key 1
        KEY[1] = 1'b0;
        step(10);
        chk("t1_press_quiet", 32'(evt_bus.event_valid), 32'd0);
        single_release("t1", 1);
        chk("t1_ovf", 32'(evt_bus.overflow), 32'd0);

        // Bounce on key 0: 2-cycle pulses never settle
        for (int i = 0; i < 10; i++) begin
            KEY[0] = i[0];
            step(2);
            chk("t2_bounce", 32'(evt_bus.event_valid), 32'd0);
        end
        KEY[0] = 1'b0;
        step(10);
        chk("t2_hold_low", 32'(evt_bus.event_valid), 32'd0);
        single_release("t2", 0);

        // Simultaneous releases, pointer back at key 2
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        for (int r = 0; r < 2; r++) begin
            KEY = 3'b000;
            step(10);
            KEY = 3'b111;
            step(7);
            chk("t3_pre", 32'(evt_bus.event_valid), 32'd0);
            for (int k = 0; k < 3; k++) begin
                step(1);
                chk("t3_valid", 32'(evt_bus.event_valid), 32'd1);
                chk("t3_id", 32'(evt_bus.event_id), 32'(k));
            end
            step(1);
            chk("t3_empty", 32'(evt_bus.event_valid), 32'd0);
        end

        // Backpressure: FIFO fills 0,1,2,0; keys 1,2 wait pending
        evt_bus.event_ready = 1'b0;
        for (int e = 0; e < 6; e++) begin
            press(e % 3);
            queued_release(e % 3);
            chk("t4_stall_valid", 32'(evt_bus.event_valid), 32'd1);
            chk("t4_stall_id", 32'(evt_bus.event_id), 32'd0);
        end
        evt_bus.event_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("t4_drain_valid", 32'(evt_bus.event_valid), 32'd1);
            chk("t4_drain_id", 32'(evt_bus.event_id), 32'(exp4[i]));
        end
        step(1);
        chk("t4_empty", 32'(evt_bus.event_valid), 32'd0);
        chk("t4_ovf", 32'(evt_bus.overflow), 32'd0);

        // Overflow: key 2 released twice while its pending bit is held
        evt_bus.event_ready = 1'b0;
        for (int e = 0; e < 5; e++) begin
            press((e == 3) ? 0 : ((e == 4) ? 2 : e));
            queued_release((e == 3) ? 0 : ((e == 4) ? 2 : e));
        end
        chk("t5_ovf_before", 32'(evt_bus.overflow), 32'd0);
        press(2);
        queued_release(2);
        chk("t5_ovf_set", 32'(evt_bus.overflow), 32'd1);
        evt_bus.event_ready = 1'b1;
        chk("t5_head", 32'(evt_bus.event_id), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("t5_drain_valid", 32'(evt_bus.event_valid), 32'd1);
            chk("t5_drain_id", 32'(evt_bus.event_id), 32'(exp5[i]));
        end
        step(1);
        chk("t5_empty", 32'(evt_bus.event_valid), 32'd0);
        step(5);
        chk("t5_no_extra", 32'(evt_bus.event_valid), 32'd0);
        chk("t5_ovf_sticky", 32'(evt_bus.overflow), 32'd1);

        // Reset mid-operation: 3 queued events and a half-counted release
        evt_bus.event_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            press(k);
            queued_release(k);
        end
        chk("t6_queued", 32'(evt_bus.event_valid), 32'd1);
        press(0);
        step(4);
        KEY[0] = 1'b1;
        step(4);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("t6_rst_valid", 32'(evt_bus.event_valid), 32'd0);
        chk("t6_rst_id", 32'(evt_bus.event_id), 32'd0);
        chk("t6_rst_ovf", 32'(evt_bus.overflow), 32'd0);
        evt_bus.event_ready = 1'b1;
        step(12);
        chk("t6_no_event", 32'(evt_bus.event_valid), 32'd0);
        press(0);
        single_release("t6_fresh", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
